bot_motion: RTL and testbench
=============================

# bot_motion

Tilt-driven position engine for the Labyrinth bot. Once per video frame it integrates the accelerometer X/Y tilt into a signed velocity and a sub-pixel position, clamps that position to the playfield, and asks the maze map whether the candidate pixel is a wall. It publishes the integer position `bot_LocX`/`bot_LocY` that the icon-drawing stage uses to place the 15x15 bot icon, so the outputs change only at a frame-synchronous commit.

## Interface
- `X_MIN`, 7: smallest legal LocX (icon half-width).
- `X_MAX`, 632: largest legal LocX.
- `Y_MIN`, 7: smallest legal LocY.
- `Y_MAX`, 472: largest legal LocY.
- `START_X`, 320: LocX after reset.
- `START_Y`, 240: LocY after reset.
- `DEADZONE`, 8: tilt magnitudes below this value are treated as 0.
- `VMAX`, 63: velocity saturation magnitude, in 1/16 pixel per frame.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `frame_tick` in 1: one-cycle pulse per frame, asserted in vertical blank.
- `accel_x`, `accel_y` in 8 each: signed two's-complement tilt.
- `wall_req` out 1: map query request.
- `wall_qx` out 10: query column.
- `wall_qy` out 10: query row.
- `wall_ack` in 1: query answered.
- `wall_hit` in 1: query pixel is a wall. Valid only when `wall_ack`=1.
- `bot_LocX`, `bot_LocY` out 10 each: committed bot centre position.
- `moving` out 1: 1 when either velocity is nonzero after commit.
- `bump` out 1: one-cycle pulse at commit if any axis clamped or hit a wall.
- `overrun` out 1: sticky flag, set when `frame_tick` arrives while the block is busy.

## Operation
- **State machine:** IDLE, VEL, CHK_X, CHK_Y, COMMIT.
  - IDLE → VEL on `frame_tick`.
  - VEL → CHK_X.
  - CHK_X → CHK_Y when `wall_ack` is seen, or immediately on a skip.
  - CHK_Y → COMMIT on the same rule.
  - COMMIT → IDLE.
- **Internal state:** `vx`, `vy` are 8-bit signed velocities. `px`, `py` are 14-bit unsigned 10.4 fixed-point positions.
- **VEL (per axis a, v):**
  - If |a| < DEADZONE: v moves one step toward 0; a value already at 0 stays 0.
  - Otherwise: v ← sat(v + (a >>> 2), −VMAX, +VMAX). The shift is arithmetic.
  - Candidate: c = p + sign_extend(v), computed 15-bit signed.
  - If c < MIN<<4, c becomes MIN<<4 and the axis is marked clamped. If c > MAX<<4, c becomes MAX<<4 and the axis is marked clamped. Either way v ← 0.
- **CHK_X:**
  - If c_x[13:4] == px[13:4], skip: no request, the candidate is accepted, and the state lasts one cycle.
  - Otherwise drive `wall_req`=1 with `wall_qx` = c_x[13:4] and `wall_qy` = py[13:4]. Hold both stable until `wall_ack`.
  - On `wall_ack` with `wall_hit`=1: reject the candidate, vx ← 0, mark the axis bumped.
  - On `wall_ack` with `wall_hit`=0: px ← c_x.
- **CHK_Y:** same procedure using `wall_qx` = the updated px[13:4] and `wall_qy` = c_y[13:4].
- **COMMIT:**
  - `bot_LocX` ← px[13:4]; `bot_LocY` ← py[13:4].
  - `moving` ← (vx≠0 | vy≠0).
  - `bump` pulses if any axis was clamped or bumped.
- **frame_tick outside IDLE:** ignored and sets `overrun`. `overrun` clears only on reset.
- **Reset** (asynchronous, at any point including while waiting for ack):
  - state=IDLE, `wall_req`=0, `wall_qx`=`wall_qy`=0.
  - px=START_X<<4, py=START_Y<<4, vx=vy=0.
  - `bot_LocX`=START_X, `bot_LocY`=START_Y.
  - `moving`=0, `bump`=0, `overrun`=0.

## Timing
- `frame_tick` is sampled at edge n.
  - Minimum latency (ack in the first CHK cycle, or skip): VEL at n+1, CHK_X at n+2, CHK_Y at n+3, `bot_LocX`/`bot_LocY`/`moving`/`bump` update at edge n+4.
  - Each cycle `wall_ack` is withheld adds one cycle.
- `wall_ack` may be combinational from `wall_req`; it is only honoured while `wall_req`=1.
- `wall_req` drops in the cycle after the ack is accepted.
- `bump` is high for exactly one cycle. All outputs are registered.
- Outputs stay constant between commits, so the icon stage never sees a mid-frame change.

## Test plan
- **Reset value:** assert `reset_n`=0 mid-CHK_X with `wall_req`=1 → `wall_req` drops asynchronously; `bot_LocX`=320, `bot_LocY`=240, `overrun`=0.
- **Integration:** `accel_x`=+40, `accel_y`=0, `wall_ack`=1, `wall_hit`=0, two ticks →
  - Tick 1: vx=10, px=5130, X query skipped, LocX=320.
  - Tick 2: vx=20, px=5150, one request with `wall_qx`=321, LocX=321 at edge n+4.
- **Deadzone/decay:** after vx=3, apply `accel_x`=+5 for 4 ticks → vx goes 2, 1, 0, 0; `moving` falls to 0 after the third tick.
- **Wall hit:** X query answered with `wall_hit`=1 → LocX unchanged, vx=0, `bump` pulses once; the Y axis is still processed normally.
- **Clamp:** px=632<<4, vx=+63, `accel_x`=+127 → LocX stays 632, vx=0, `bump`=1, no X request; repeat at X_MIN with negative tilt → LocX=7.
- **Overrun/handshake:** hold `wall_ack`=0 for 10 cycles while pulsing `frame_tick` → `wall_qx`/`wall_qy` stay stable, `overrun`=1, no second update occurs; releasing ack completes the single frame.

Source files
------------

// File: rtl/bot_motion.sv
// bot_motion: tilt-driven position engine for the Labyrinth bot.
// Once per frame it integrates accelerometer tilt into a signed velocity and a
// 10.4 fixed-point position, clamps to the playfield, asks the maze map whether
// the candidate pixel is a wall, and commits the integer position for the icon
// stage. Outputs only change at the commit, never mid-frame.
//
// Ports:
//   clk, reset_n        system clock, async active-low reset
//   frame_tick          one-cycle pulse per frame (vertical blank)
//   accel_x, accel_y    signed 8-bit tilt
//   wall_req/qx/qy      map query (held stable until wall_ack)
//   wall_ack, wall_hit  map answer; wall_hit valid only with wall_ack
//   bot_LocX, bot_LocY  committed bot centre (pixels)
//   moving              either velocity nonzero after commit
//   bump                one-cycle pulse at commit on clamp or wall hit
//   overrun             sticky: frame_tick seen while busy
//
// state    | meaning
// S_IDLE   | waiting for frame_tick
// S_VEL    | update velocities, form and clamp candidates, launch X query
// S_CHK_X  | wait for X answer (or skip), launch Y query
// S_CHK_Y  | wait for Y answer (or skip)
// S_COMMIT | publish position, moving, bump
module bot_motion #(
  parameter int X_MIN    = 7,
  parameter int X_MAX    = 632,
  parameter int Y_MIN    = 7,
  parameter int Y_MAX    = 472,
  parameter int START_X  = 320,
  parameter int START_Y  = 240,
  parameter int DEADZONE = 8,
  parameter int VMAX     = 63
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic [7:0] accel_x,
  input  logic [7:0] accel_y,
  output logic       wall_req,
  output logic [9:0] wall_qx,
  output logic [9:0] wall_qy,
  input  logic       wall_ack,
  input  logic       wall_hit,
  output logic [9:0] bot_LocX,
  output logic [9:0] bot_LocY,
  output logic       moving,
  output logic       bump,
  output logic       overrun
);

  localparam logic signed [9:0]  DZ     = 10'(DEADZONE);
  localparam logic signed [9:0]  VM     = 10'(VMAX);
  localparam logic signed [15:0] CX_LO  = 16'(X_MIN * 16);
  localparam logic signed [15:0] CX_HI  = 16'(X_MAX * 16);
  localparam logic signed [15:0] CY_LO  = 16'(Y_MIN * 16);
  localparam logic signed [15:0] CY_HI  = 16'(Y_MAX * 16);
  localparam logic [13:0]        PX_RST = 14'(START_X * 16);
  localparam logic [13:0]        PY_RST = 14'(START_Y * 16);
  localparam logic [9:0]         LX_RST = 10'(START_X);
  localparam logic [9:0]         LY_RST = 10'(START_Y);

  typedef enum logic [2:0] {S_IDLE, S_VEL, S_CHK_X, S_CHK_Y, S_COMMIT} state_t;

  state_t state, state_nx;

  logic signed [7:0] vx, vy, vx_nx, vy_nx;
  logic [13:0]       px, py, px_nx, py_nx;
  logic [13:0]       cx, cy, cx_nx, cy_nx;
  logic              pend, pend_nx;
  logic              req_nx;
  logic [9:0]        qx_nx, qy_nx, locx_nx, locy_nx;
  logic              moving_nx, bump_nx;

  logic signed [7:0]  vx_step, vy_step;
  logic signed [15:0] cx_raw, cy_raw;
  logic [13:0]        cx_lim, cy_lim;
  logic               clamp_x, clamp_y;
  logic               chk_go, chk_hit;

  // Deadzone decays one step toward zero; otherwise add a/4 and saturate.
  function automatic logic signed [7:0] vel_step(input logic signed [7:0] v,
                                                 input logic signed [7:0] a);
    logic signed [9:0] a10, v10, sum, r;
    a10 = {{2{a[7]}}, a};
    v10 = {{2{v[7]}}, v};
    if (a10 > -DZ && a10 < DZ) begin
      if (v10 > 10'sd0)      r = v10 - 10'sd1;
      else if (v10 < 10'sd0) r = v10 + 10'sd1;
      else                   r = v10;
    end else begin
      sum = v10 + (a10 >>> 2);
      if (sum > VM)       r = VM;
      else if (sum < -VM) r = -VM;
      else                r = sum;
    end
    return r[7:0];
  endfunction

  function automatic logic signed [15:0] cand(input logic [13:0] p,
                                              input logic signed [7:0] v);
    return $signed({2'b00, p}) + $signed({{8{v[7]}}, v});
  endfunction

  always_comb begin
    vx_step = vel_step(vx, accel_x);
    vy_step = vel_step(vy, accel_y);
    cx_raw  = cand(px, vx_step);
    cy_raw  = cand(py, vy_step);
    clamp_x = 1'b0;
    clamp_y = 1'b0;
    cx_lim  = cx_raw[13:0];
    cy_lim  = cy_raw[13:0];
    if (cx_raw < CX_LO) begin
      cx_lim  = CX_LO[13:0];
      clamp_x = 1'b1;
    end else if (cx_raw > CX_HI) begin
      cx_lim  = CX_HI[13:0];
      clamp_x = 1'b1;
    end
    if (cy_raw < CY_LO) begin
      cy_lim  = CY_LO[13:0];
      clamp_y = 1'b1;
    end else if (cy_raw > CY_HI) begin
      cy_lim  = CY_HI[13:0];
      clamp_y = 1'b1;
    end
  end

  // A check state advances on an accepted ack, or at once when no query was
  // launched (candidate stays on the same integer pixel).
  assign chk_go  = ~wall_req | wall_ack;
  assign chk_hit = wall_req & wall_ack & wall_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (frame_tick) state_nx = S_VEL;
      S_VEL:    state_nx = S_CHK_X;
      S_CHK_X:  if (chk_go) state_nx = S_CHK_Y;
      S_CHK_Y:  if (chk_go) state_nx = S_COMMIT;
      S_COMMIT: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    vx_nx     = vx;
    vy_nx     = vy;
    px_nx     = px;
    py_nx     = py;
    cx_nx     = cx;
    cy_nx     = cy;
    pend_nx   = pend;
    req_nx    = wall_req;
    qx_nx     = wall_qx;
    qy_nx     = wall_qy;
    locx_nx   = bot_LocX;
    locy_nx   = bot_LocY;
    moving_nx = moving;
    bump_nx   = 1'b0;
    case (state)
      S_VEL: begin
        vx_nx   = clamp_x ? 8'sd0 : vx_step;
        vy_nx   = clamp_y ? 8'sd0 : vy_step;
        cx_nx   = cx_lim;
        cy_nx   = cy_lim;
        pend_nx = clamp_x | clamp_y;
        req_nx  = (cx_lim[13:4] != px[13:4]);
        if (req_nx) begin
          qx_nx = cx_lim[13:4];
          qy_nx = py[13:4];
        end
      end
      S_CHK_X: begin
        if (chk_go) begin
          if (chk_hit) begin
            vx_nx   = 8'sd0;
            pend_nx = 1'b1;
          end else begin
            px_nx = cx;
          end
          // Y query is issued against the X position just decided.
          req_nx = (cy[13:4] != py[13:4]);
          if (req_nx) begin
            qx_nx = px_nx[13:4];
            qy_nx = cy[13:4];
          end
        end
      end
      S_CHK_Y: begin
        if (chk_go) begin
          if (chk_hit) begin
            vy_nx   = 8'sd0;
            pend_nx = 1'b1;
          end else begin
            py_nx = cy;
          end
          req_nx = 1'b0;
        end
      end
      S_COMMIT: begin
        locx_nx   = px[13:4];
        locy_nx   = py[13:4];
        moving_nx = (vx != 8'sd0) | (vy != 8'sd0);
        bump_nx   = pend;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vx       <= 8'sd0;
      vy       <= 8'sd0;
      px       <= PX_RST;
      py       <= PY_RST;
      cx       <= PX_RST;
      cy       <= PY_RST;
      pend     <= 1'b0;
      wall_req <= 1'b0;
      wall_qx  <= 10'd0;
      wall_qy  <= 10'd0;
      bot_LocX <= LX_RST;
      bot_LocY <= LY_RST;
      moving   <= 1'b0;
      bump     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      vx       <= vx_nx;
      vy       <= vy_nx;
      px       <= px_nx;
      py       <= py_nx;
      cx       <= cx_nx;
      cy       <= cy_nx;
      pend     <= pend_nx;
      wall_req <= req_nx;
      wall_qx  <= qx_nx;
      wall_qy  <= qy_nx;
      bot_LocX <= locx_nx;
      bot_LocY <= locy_nx;
      moving   <= moving_nx;
      bump     <= bump_nx;
      if (frame_tick && state != S_IDLE) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bot_motion.sv
// tb_bot_motion: scenario bench for bot_motion. A behavioural model predicts
// each frame's outcome when the frame is launched; the prediction is queued and
// popped at the commit edge for comparison.
module tb_bot_motion;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic [7:0] accel_x = 8'd0;
  logic [7:0] accel_y = 8'd0;
  logic       wall_req;
  logic [9:0] wall_qx, wall_qy;
  logic       wall_ack, wall_hit;
  logic [9:0] bot_LocX, bot_LocY;
  logic       moving, bump, overrun;

  logic       ack_en = 1'b1;
  logic       hit_x_en = 1'b0, hit_y_en = 1'b0;
  logic [9:0] xqx = '0, xqy = '0, yqx = '0, yqy = '0;

  int n_cmp = 0;
  int n_err = 0;

  int mpx, mpy, mvx, mvy;

  typedef struct {
    int locx;
    int locy;
    bit mov;
    bit bmp;
    int nreq;
    int qx;
  } exp_t;
  exp_t sb[$];
  logic [9:0] acc_q[$];

  bot_motion dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
    .accel_x(accel_x), .accel_y(accel_y),
    .wall_req(wall_req), .wall_qx(wall_qx), .wall_qy(wall_qy),
    .wall_ack(wall_ack), .wall_hit(wall_hit),
    .bot_LocX(bot_LocX), .bot_LocY(bot_LocY),
    .moving(moving), .bump(bump), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Map responder: answers immediately when enabled; a wall is reported only
  // for the exact query the model flagged as a hit.
  assign wall_ack = wall_req & ack_en;
  assign wall_hit = wall_ack &
                    ((hit_x_en && wall_qx == xqx && wall_qy == xqy) ||
                     (hit_y_en && wall_qx == yqx && wall_qy == yqy));

  always @(posedge clk)
    if (wall_req && wall_ack) acc_q.push_back(wall_qx);

  function automatic int vstep(input int v, input int a);
    int s;
    if (a > -8 && a < 8) return (v > 0) ? v - 1 : ((v < 0) ? v + 1 : 0);
    s = v + (a >>> 2);
    if (s > 63) s = 63;
    if (s < -63) s = -63;
    return s;
  endfunction

  task automatic model_reset();
    mpx = 320 * 16;
    mpy = 240 * 16;
    mvx = 0;
    mvy = 0;
    sb.delete();
    hit_x_en = 1'b0;
    hit_y_en = 1'b0;
  endtask

  task automatic model_frame(input int ax, input int ay, input bit hx, input bit hy);
    exp_t e;
    int c, d, n, fq;
    bit bm;
    bm  = 0;
    mvx = vstep(mvx, ax);
    mvy = vstep(mvy, ay);
    c = mpx + mvx;
    d = mpy + mvy;
    if (c < 7 * 16)        begin c = 7 * 16;   mvx = 0; bm = 1; end
    else if (c > 632 * 16) begin c = 632 * 16; mvx = 0; bm = 1; end
    if (d < 7 * 16)        begin d = 7 * 16;   mvy = 0; bm = 1; end
    else if (d > 472 * 16) begin d = 472 * 16; mvy = 0; bm = 1; end
    n  = 0;
    fq = -1;
    if (c / 16 != mpx / 16) begin
      n++;
      fq = c / 16;
      xqx = 10'(c / 16);
      xqy = 10'(mpy / 16);
      if (hx) begin mvx = 0; bm = 1; end
      else mpx = c;
    end else begin
      mpx = c;
    end
    if (d / 16 != mpy / 16) begin
      n++;
      if (fq < 0) fq = mpx / 16;
      yqx = 10'(mpx / 16);
      yqy = 10'(d / 16);
      if (hy) begin mvy = 0; bm = 1; end
      else mpy = d;
    end else begin
      mpy = d;
    end
    hit_x_en = hx;
    hit_y_en = hy;
    e.locx = mpx / 16;
    e.locy = mpy / 16;
    e.mov  = (mvx != 0 || mvy != 0);
    e.bmp  = bm;
    e.nreq = n;
    e.qx   = fq;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    frame_tick = 1'b0;
    ack_en     = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  // One frame with an always-ready map: commit lands exactly 4 edges after the
  // edge that samples frame_tick.
  task automatic run_frame(input int ax, input int ay, input bit hx, input bit hy,
                           input string nm);
    exp_t e;
    int base, oldx, oldy;
    @(negedge clk);
    accel_x = ax[7:0];
    accel_y = ay[7:0];
    oldx = mpx / 16;
    oldy = mpy / 16;
    model_frame(ax, ay, hx, hy);
    base = acc_q.size();
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (bot_LocX !== 10'(oldx) || bot_LocY !== 10'(oldy)) begin
      n_err++;
      $display("FAIL %s_hold: loc=(%0d,%0d) required (%0d,%0d) before commit",
               nm, bot_LocX, bot_LocY, oldx, oldy);
    end
    @(posedge clk); #1;
    e = sb.pop_front();
    n_cmp++;
    if (bot_LocX !== 10'(e.locx) || bot_LocY !== 10'(e.locy)) begin
      n_err++;
      $display("FAIL %s_loc: got (%0d,%0d) required (%0d,%0d)",
               nm, bot_LocX, bot_LocY, e.locx, e.locy);
    end
    n_cmp++;
    if (moving !== e.mov || bump !== e.bmp) begin
      n_err++;
      $display("FAIL %s_flags: moving=%b bump=%b required moving=%b bump=%b",
               nm, moving, bump, e.mov, e.bmp);
    end
    n_cmp++;
    if (acc_q.size() - base != e.nreq) begin
      n_err++;
      $display("FAIL %s_nreq: got %0d required %0d", nm, acc_q.size() - base, e.nreq);
    end else if (e.nreq > 0) begin
      n_cmp++;
      if (acc_q[base] !== 10'(e.qx)) begin
        n_err++;
        $display("FAIL %s_qx: got %0d required %0d", nm, acc_q[base], e.qx);
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bump !== 1'b0) begin
      n_err++;
      $display("FAIL %s_bump_width: bump=%b required 0", nm, bump);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++;
    if (bot_LocX !== 10'd320 || bot_LocY !== 10'd240 || moving !== 1'b0 ||
        bump !== 1'b0 || overrun !== 1'b0 || wall_req !== 1'b0 ||
        wall_qx !== 10'd0 || wall_qy !== 10'd0) begin
      n_err++;
      $display("FAIL reset_values: loc=(%0d,%0d) mv=%b bp=%b ov=%b req=%b q=(%0d,%0d) required (320,240) 0 0 0 0 (0,0)",
               bot_LocX, bot_LocY, moving, bump, overrun, wall_req, wall_qx, wall_qy);
    end
    ack_en = 1'b0;
    @(negedge clk);
    accel_x = 8'd127;
    accel_y = 8'd0;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    for (int i = 0; i < 6 && wall_req !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    n_cmp++;
    if (wall_req !== 1'b1) begin
      n_err++;
      $display("FAIL reset_req_timeout: wall_req=%b required 1", wall_req);
    end
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (wall_req !== 1'b0 || bot_LocX !== 10'd320 || bot_LocY !== 10'd240 ||
        overrun !== 1'b0 || wall_qx !== 10'd0) begin
      n_err++;
      $display("FAIL reset_async: req=%b loc=(%0d,%0d) ov=%b qx=%0d required 0 (320,240) 0 0",
               wall_req, bot_LocX, bot_LocY, overrun, wall_qx);
    end
    @(negedge clk);
    reset_n = 1'b1;
    ack_en  = 1'b1;
    accel_x = 8'd0;
    model_reset();
  endtask

  task automatic test_integration();
    do_reset();
    run_frame(40, 0, 0, 0, "int_tick1");
    run_frame(40, 0, 0, 0, "int_tick2");
    run_frame(-60, 100, 0, 0, "int_diag");
    run_frame(-60, -100, 0, 0, "int_diag2");
  endtask

  task automatic test_deadzone();
    do_reset();
    run_frame(12, 0, 0, 0, "dz_seed");
    for (int i = 0; i < 4; i++) run_frame(5, -7, 0, 0, "dz_decay");
    n_cmp++;
    if (moving !== 1'b0) begin
      n_err++;
      $display("FAIL dz_moving: moving=%b required 0", moving);
    end
  endtask

  task automatic test_wall_hit();
    do_reset();
    run_frame(127, 127, 1, 0, "hit_x");
    run_frame(127, 127, 0, 1, "hit_y");
    run_frame(-127, 0, 1, 0, "hit_xneg");
  endtask

  task automatic test_clamp();
    do_reset();
    for (int i = 0; i < 200 && mpx / 16 != 632; i++) run_frame(127, 0, 0, 0, "clamp_run_hi");
    run_frame(127, 0, 0, 0, "clamp_hi");
    n_cmp++;
    if (bot_LocX !== 10'd632) begin
      n_err++;
      $display("FAIL clamp_hi_loc: LocX=%0d required 632", bot_LocX);
    end
    for (int i = 0; i < 300 && mpx / 16 != 7; i++) run_frame(-128, 0, 0, 0, "clamp_run_lo");
    run_frame(-128, 0, 0, 0, "clamp_lo");
    n_cmp++;
    if (bot_LocX !== 10'd7) begin
      n_err++;
      $display("FAIL clamp_lo_loc: LocX=%0d required 7", bot_LocX);
    end
  endtask

  task automatic test_overrun();
    exp_t e;
    int bad;
    do_reset();
    ack_en = 1'b0;
    @(negedge clk);
    accel_x = 8'd127;
    accel_y = 8'd0;
    model_frame(127, 0, 0, 0);
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    for (int i = 0; i < 6 && wall_req !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    n_cmp++;
    if (wall_req !== 1'b1 || wall_qx !== xqx || wall_qy !== xqy) begin
      n_err++;
      $display("FAIL ovr_query: req=%b q=(%0d,%0d) required 1 (%0d,%0d)",
               wall_req, wall_qx, wall_qy, xqx, xqy);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      frame_tick = (i % 3 == 0);
      @(posedge clk); #1;
      frame_tick = 1'b0;
      if (wall_req !== 1'b1 || wall_qx !== xqx || wall_qy !== xqy) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL ovr_stable: %0d unstable cycles required 0", bad);
    end
    n_cmp++;
    if (overrun !== 1'b1 || bot_LocX !== 10'd320) begin
      n_err++;
      $display("FAIL ovr_flag: overrun=%b LocX=%0d required 1 320", overrun, bot_LocX);
    end
    @(negedge clk);
    ack_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    e = sb.pop_front();
    n_cmp++;
    if (bot_LocX !== 10'(e.locx) || bot_LocY !== 10'(e.locy) ||
        moving !== e.mov || bump !== e.bmp) begin
      n_err++;
      $display("FAIL ovr_commit: loc=(%0d,%0d) mv=%b bp=%b required (%0d,%0d) %b %b",
               bot_LocX, bot_LocY, moving, bump, e.locx, e.locy, e.mov, e.bmp);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (wall_req !== 1'b0 || bot_LocX !== 10'(e.locx)) bad++;
    end
    n_cmp++;
    if (bad != 0 || overrun !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_single: %0d extra-activity cycles overrun=%b required 0 1", bad, overrun);
    end
  endtask

  initial begin
    test_reset();
    test_integration();
    test_deadzone();
    test_wall_hit();
    test_clamp();
    test_overrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
